phy_rx_sync_deframer: RTL and testbench
=======================================

Name: phy_rx_sync_deframer

Overview:
Receive-side counterpart of the PHY TX output stage. It sits after the RX deserializer in the clk_8f domain and takes one byte per enabled cycle plus a control-character flag. It acquires lane sync by counting consecutive comma characters, then strips idle commas and presents registered data bytes with a valid qualifier. Repeated invalid control characters drop it back to sync search.

Parameters:
COMMA, 8'hBC, control byte used for sync and idle fill.
SYNC_COUNT, 4, consecutive commas required to declare sync (range 1..15).
LOSS_COUNT, 3, consecutive invalid control characters that drop sync (range 1..15).

Ports:
clk_8f  input  1  byte clock; all logic on its rising edge.
reset  input  1  synchronous, active-low.
byte_en  input  1  deserializer has a byte this cycle; qualifies data_in/k_in.
data_in  input  8  received byte.
k_in  input  1  1 = data_in is a control character, 0 = data character.
data_out0  output  8  registered data byte.
valid_out0  output  1  data_out0 carries a new data byte this cycle.
active  output  1  lane synchronized.
err_out  output  1  one-cycle pulse per invalid control character while active.

Behaviour:
- Reset: reset sampled 0 at a clk_8f edge -> state SEARCH, comma_cnt=0, err_cnt=0, data_out0=8'h00, valid_out0=0, active=0, err_out=0 after that edge. Reset applies mid-operation and overrides all other inputs.
- All outputs are registered. Latency from input byte to output is exactly 1 clk_8f cycle.
- Counter widths: 4 bits. Counters never wrap because they clear at their threshold.
- Comma byte means k_in=1 and data_in==COMMA. Bad control byte means k_in=1 and data_in!=COMMA.
- byte_en=0:
  - State, comma_cnt and err_cnt hold.
  - valid_out0<=0, err_out<=0, data_out0 holds, active holds.
  - A gap does not break a comma run.
- State SEARCH (active=0, valid_out0 always 0, err_out always 0):
  - Comma byte: comma_cnt+1. If the new count equals SYNC_COUNT, go to ACTIVE, set active<=1 on the same edge, and clear comma_cnt.
  - Any other byte, including k_in=0 with data 8'hBC: comma_cnt<=0.
- State ACTIVE (active=1):
  - k_in=0: data_out0<=data_in, valid_out0<=1, err_cnt<=0.
  - Comma byte (idle): valid_out0<=0, data_out0 holds, err_cnt<=0.
  - Bad control byte: valid_out0<=0, data_out0 holds, err_out<=1 for this cycle, err_cnt+1. If the new count equals LOSS_COUNT, go to SEARCH, set active<=0 on the same edge, and clear err_cnt and comma_cnt.
- Data is never delivered on the same edge that active rises. The first possible valid_out0 is on the cycle after the sync-completing comma.
- data_out0 is meaningful only when valid_out0=1. Otherwise it holds the last delivered byte, or 0 after reset.

Test Plan:
1. Reset low 2 cycles, then 4 comma bytes (k=1, 0xBC), byte_en=1 -> active=1 at the edge sampling the 4th comma. valid_out0=0 throughout. Repeat with 3 commas then k=0 0x10 -> active stays 0.
2. Sync acquired, then k=0 bytes 0x11, 0x22 on consecutive cycles -> data_out0=0x11 then 0x22, each one cycle later, with valid_out0=1 on both cycles.
3. Active, k=0 0x22 then a comma byte -> valid_out0=0 and data_out0 holds 0x22. Then k=0 0xBC -> data_out0=0xBC, valid_out0=1.
4. Active, three k=1 0x55 bytes -> err_out pulses on each of the 3 output cycles, and active falls at the 3rd. Alternate case: two 0x55 bytes then a comma -> active stays 1, err_cnt clears, and a further single 0x55 does not drop sync.
5. SEARCH, commas interleaved with byte_en=0 gaps of 1–3 cycles -> sync acquired after the 4th enabled comma. Gap cycles show valid_out0=0.
6. Active, streaming data, reset driven low for 1 cycle -> next edge gives data_out0=0x00, valid_out0=0, active=0, err_out=0. Four fresh commas are then required to re-sync.

Source files
------------

// File: rtl/phy_rx_sync_deframer.sv
// RX deframer: acquires lane sync on a run of commas, strips idle commas,
// delivers data bytes one cycle later and drops sync on repeated bad control chars.
module phy_rx_sync_deframer #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4,
    parameter int         LOSS_COUNT = 3
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       byte_en,
    input  logic [7:0] data_in,
    input  logic       k_in,
    output logic [7:0] data_out0,
    output logic       valid_out0,
    output logic       active,
    output logic       err_out
);

    localparam logic [3:0] SYNC_TH = 4'(SYNC_COUNT);
    localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);

    typedef enum logic {SEARCH, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       err_q, err_d;

    logic is_comma, is_bad;
    assign is_comma = k_in && (data_in == COMMA);
    assign is_bad   = k_in && (data_in != COMMA);

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        active_d    = active_q;
        err_d       = 1'b0;
        if (byte_en) begin
            unique case (state_q)
                SEARCH: begin
                    // Only a true comma extends the run; k=0 0xBC is data and breaks it.
                    if (is_comma) begin
                        if (comma_cnt_q + 4'd1 == SYNC_TH) begin
                            state_d     = ACTIVE;
                            active_d    = 1'b1;
                            comma_cnt_d = 4'd0;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                        end
                    end else begin
                        comma_cnt_d = 4'd0;
                    end
                end
                ACTIVE: begin
                    if (!k_in) begin
                        data_d    = data_in;
                        valid_d   = 1'b1;
                        err_cnt_d = 4'd0;
                    end else if (is_bad) begin
                        err_d = 1'b1;
                        if (err_cnt_q + 4'd1 == LOSS_TH) begin
                            state_d     = SEARCH;
                            active_d    = 1'b0;
                            err_cnt_d   = 4'd0;
                            comma_cnt_d = 4'd0;
                        end else begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                    end else begin
                        err_cnt_d = 4'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q     <= SEARCH;
            comma_cnt_q <= 4'd0;
            err_cnt_q   <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            err_q       <= err_d;
        end
    end

    assign data_out0  = data_q;
    assign valid_out0 = valid_q;
    assign active     = active_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_phy_rx_sync_deframer.sv
// Vector-table bench for phy_rx_sync_deframer; expectations queued at drive time
// and checked one cycle later against the registered outputs.
module tb_phy_rx_sync_deframer;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b0;
    logic       byte_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       k_in = 1'b0;
    logic [7:0] data_out0;
    logic       valid_out0, active, err_out;

    phy_rx_sync_deframer dut (
        .clk_8f(clk_8f), .reset(reset), .byte_en(byte_en), .data_in(data_in),
        .k_in(k_in), .data_out0(data_out0), .valid_out0(valid_out0),
        .active(active), .err_out(err_out)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        logic       rst_n, en, k;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        logic       ea, ee;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a, e;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic rst_n, en, k, input logic [7:0] d,
                       input logic ev, input logic [7:0] ed, input logic ea, ee);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.k = k; v.d = d;
        v.ev = ev; v.ed = ed; v.ea = ea; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input int id, input logic [7:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h exp %h", nm, id, act, exp);
        end
    endtask

    // Drive one byte, queue its expected result, then check after the sampling edge.
    task automatic apply(input vec_t v, input int id);
        exp_t e, got;
        @(negedge clk_8f);
        reset = v.rst_n; byte_en = v.en; k_in = v.k; data_in = v.d;
        e.v = v.ev; e.d = v.ed; e.a = v.ea; e.e = v.ee; e.id = id;
        sb.push_back(e);
        @(posedge clk_8f);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty vec %0d", id);
        end else begin
            got = sb.pop_front();
            cmp("valid_out0", got.id, {7'd0, valid_out0}, {7'd0, got.v});
            cmp("data_out0",  got.id, data_out0, got.d);
            cmp("active",     got.id, {7'd0, active}, {7'd0, got.a});
            cmp("err_out",    got.id, {7'd0, err_out}, {7'd0, got.e});
        end
    endtask

    initial begin
        vec_t g;
        int gap;
        // reset, then sync on 4 commas
        add(0,1,0,8'h00, 0,8'h00,0,0);
        add(0,1,0,8'h00, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,1,0);
        // streaming data, idle comma, k=0 0xBC as data
        add(1,1,0,8'h11, 1,8'h11,1,0);
        add(1,1,0,8'h22, 1,8'h22,1,0);
        add(1,1,1,8'hBC, 0,8'h22,1,0);
        add(1,1,0,8'hBC, 1,8'hBC,1,0);
        // two bad, comma clears, single bad keeps sync
        add(1,1,1,8'h55, 0,8'hBC,1,1);
        add(1,1,1,8'h55, 0,8'hBC,1,1);
        add(1,1,1,8'hBC, 0,8'hBC,1,0);
        add(1,1,1,8'h55, 0,8'hBC,1,1);
        add(1,1,0,8'h33, 1,8'h33,1,0);
        // three bad in a row drop sync on the third
        add(1,1,1,8'h55, 0,8'h33,1,1);
        add(1,1,1,8'h55, 0,8'h33,1,1);
        add(1,1,1,8'h55, 0,8'h33,0,1);
        add(1,1,0,8'h44, 0,8'h33,0,0);
        add(1,1,1,8'h55, 0,8'h33,0,0);
        // 3 commas then data breaks the run; k=0 0xBC also breaks it
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,0,8'h10, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,0,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,0,0);
        add(1,1,1,8'hBC, 0,8'h33,1,0);
        // mid-stream reset, then a full re-sync is needed
        add(1,1,0,8'h66, 1,8'h66,1,0);
        add(0,1,0,8'h77, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,0,0);
        add(1,1,1,8'hBC, 0,8'h00,1,0);
        add(1,1,0,8'h88, 1,8'h88,1,0);
        // byte_en=0 ignores the bus
        add(1,0,1,8'h55, 0,8'h88,1,0);
        add(1,0,0,8'h99, 0,8'h88,1,0);
        add(1,1,1,8'h55, 0,8'h88,1,1);
        add(1,0,1,8'h55, 0,8'h88,1,0);
        add(1,1,1,8'h55, 0,8'h88,1,1);
        add(1,1,1,8'h55, 0,8'h88,0,1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // commas separated by random gaps of 1..3 disabled cycles
        g.rst_n = 0; g.en = 1; g.k = 0; g.d = 8'h00;
        g.ev = 0; g.ed = 8'h00; g.ea = 0; g.ee = 0;
        apply(g, 100);
        for (int c = 0; c < 4; c++) begin
            g.rst_n = 1; g.en = 1; g.k = 1; g.d = 8'hBC;
            g.ea = (c == 3);
            apply(g, 101 + c * 10);
            gap = $urandom_range(3, 1);
            for (int j = 0; j < gap; j++) begin
                g.en = 0;
                apply(g, 102 + c * 10 + j);
            end
        end
        g.en = 1; g.k = 0; g.d = 8'hA5; g.ev = 1; g.ed = 8'hA5; g.ea = 1;
        apply(g, 150);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover %0d", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
